// File: rtl/setting_sweep_ctrl_if.sv
// Result port of the setting sweep controller: one (tx, rx, err, timeout) record
// per swept point, moved with a valid/ready handshake.
interface setting_sweep_ctrl_if #(
    parameter int TX_W  = 4,
    parameter int RX_W  = 4,
    parameter int ERR_W = 32
);
    logic             res_valid;
    logic             res_ready;
    logic [TX_W-1:0]  res_tx;
    logic [RX_W-1:0]  res_rx;
    logic [ERR_W-1:0] res_err;
    logic             res_timeout;

    modport master (
        output res_valid, res_tx, res_rx, res_err, res_timeout,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_tx, res_rx, res_err, res_timeout,
        output res_ready
    );
endinterface

// File: rtl/setting_sweep_ctrl.sv
// Walks the link emulator through every (tx_setting, rx_setting) pair: reset, run,
// capture the error count, report it, advance. rx is the inner loop, tx the outer.
//
// state   | meaning
// IDLE    | parked, emulator held in reset
// APPLY   | settings applied, emu_rst held RST_CYCLES cycles
// RUN     | emulator running, waiting for qualified sim_done or timeout
// CAPTURE | latch settings of the point, raise res_valid
// REPORT  | hold result until res_ready
// NEXT    | advance rx (then tx) or finish
// DONE    | sweep complete
module setting_sweep_ctrl #(
    parameter int TX_SETTING_WIDTH = 4,
    parameter int RX_SETTING_WIDTH = 4,
    parameter int TX_MAX           = 15,
    parameter int RX_MAX           = 15,
    parameter int ERR_WIDTH        = 32,
    parameter int RST_CYCLES       = 16,
    parameter int BLANK_CYCLES     = 4,
    parameter int TIMEOUT_WIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic [TIMEOUT_WIDTH-1:0]    timeout_cycles_i,
    input  logic                        sim_done_i,
    input  logic [ERR_WIDTH-1:0]        err_count_i,
    output logic                        emu_rst_o,
    output logic [TX_SETTING_WIDTH-1:0] tx_setting_o,
    output logic [RX_SETTING_WIDTH-1:0] rx_setting_o,
    output logic                        busy_o,
    output logic                        done_o,
    setting_sweep_ctrl_if.master        res
);
    localparam int RCW = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0]              RST_LOAD = RCW'(RST_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0]    T_ONE    = TIMEOUT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0]    T_BLANK  = TIMEOUT_WIDTH'(BLANK_CYCLES);
    localparam logic [TX_SETTING_WIDTH-1:0] TX_LAST  = TX_SETTING_WIDTH'(TX_MAX);
    localparam logic [RX_SETTING_WIDTH-1:0] RX_LAST  = RX_SETTING_WIDTH'(RX_MAX);
    localparam logic [TX_SETTING_WIDTH-1:0] TX_ONE   = TX_SETTING_WIDTH'(1);
    localparam logic [RX_SETTING_WIDTH-1:0] RX_ONE   = RX_SETTING_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE, APPLY, RUN, CAPTURE, REPORT, NEXT, DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [RCW-1:0]              rst_cnt_q, rst_cnt_d;
    logic [TIMEOUT_WIDTH-1:0]    run_cnt_q, run_cnt_d;
    logic                        emu_rst_q, emu_rst_d;
    logic [TX_SETTING_WIDTH-1:0] tx_q, tx_d, res_tx_q, res_tx_d;
    logic [RX_SETTING_WIDTH-1:0] rx_q, rx_d, res_rx_q, res_rx_d;
    logic [ERR_WIDTH-1:0]        res_err_q, res_err_d;
    logic                        res_valid_q, res_valid_d;
    logic                        res_timeout_q, res_timeout_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        done_qual, timed_out;

    assign done_qual = sim_done_i && (run_cnt_q >= T_BLANK);
    assign timed_out = (timeout_cycles_i != '0) && (run_cnt_q >= timeout_cycles_i - T_ONE);

    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        run_cnt_d     = run_cnt_q;
        emu_rst_d     = emu_rst_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        res_tx_d      = res_tx_q;
        res_rx_d      = res_rx_q;
        res_err_d     = res_err_q;
        res_valid_d   = res_valid_q;
        res_timeout_d = res_timeout_q;

        unique case (state_q)
            IDLE, DONE: begin
                emu_rst_d = 1'b1;
                if (start_i) begin
                    state_d   = APPLY;
                    tx_d      = '0;
                    rx_d      = '0;
                    rst_cnt_d = RST_LOAD;
                end
            end
            APPLY: begin
                if (rst_cnt_q == '0) begin
                    state_d   = RUN;
                    emu_rst_d = 1'b0;
                    run_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q - 1'b1;
                end
            end
            RUN: begin
                // A qualified sim_done beats a timeout landing on the same cycle.
                if (done_qual || timed_out) begin
                    state_d       = CAPTURE;
                    res_err_d     = err_count_i;
                    res_timeout_d = !done_qual;
                end else if (run_cnt_q != '1) begin
                    run_cnt_d = run_cnt_q + T_ONE;
                end
            end
            CAPTURE: begin
                state_d     = REPORT;
                res_tx_d    = tx_q;
                res_rx_d    = rx_q;
                res_valid_d = 1'b1;
                emu_rst_d   = 1'b1;
            end
            REPORT: begin
                if (res.res_ready) begin
                    state_d     = NEXT;
                    res_valid_d = 1'b0;
                end
            end
            NEXT: begin
                if (rx_q < RX_LAST) begin
                    state_d   = APPLY;
                    rx_d      = rx_q + RX_ONE;
                    rst_cnt_d = RST_LOAD;
                end else if (tx_q < TX_LAST) begin
                    state_d   = APPLY;
                    rx_d      = '0;
                    tx_d      = tx_q + TX_ONE;
                    rst_cnt_d = RST_LOAD;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort_i) begin
            state_d       = IDLE;
            emu_rst_d     = 1'b1;
            res_valid_d   = 1'b0;
            tx_d          = tx_q;
            rx_d          = rx_q;
            res_err_d     = res_err_q;
            res_timeout_d = res_timeout_q;
        end

        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rst_cnt_q     <= '0;
            run_cnt_q     <= '0;
            emu_rst_q     <= 1'b1;
            tx_q          <= '0;
            rx_q          <= '0;
            res_tx_q      <= '0;
            res_rx_q      <= '0;
            res_err_q     <= '0;
            res_valid_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            run_cnt_q     <= run_cnt_d;
            emu_rst_q     <= emu_rst_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            res_tx_q      <= res_tx_d;
            res_rx_q      <= res_rx_d;
            res_err_q     <= res_err_d;
            res_valid_q   <= res_valid_d;
            res_timeout_q <= res_timeout_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign emu_rst_o       = emu_rst_q;
    assign tx_setting_o    = tx_q;
    assign rx_setting_o    = rx_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign res.res_valid   = res_valid_q;
    assign res.res_tx      = res_tx_q;
    assign res.res_rx      = res_rx_q;
    assign res.res_err     = res_err_q;
    assign res.res_timeout = res_timeout_q;
endmodule

// File: tb/tb_setting_sweep_ctrl.sv
// Bench for setting_sweep_ctrl on a 2x2 sweep: emulator model, random readiness,
// and a point-level scoreboard derived from sweep order and run-length arithmetic.
module tb_setting_sweep_ctrl;
    localparam int TXW = 4, RXW = 4, ERRW = 32, TW = 32;
    localparam int TX_MAX = 1, RX_MAX = 1, RSTC = 16, BLANK = 4;
    localparam int NPTS = (TX_MAX + 1) * (RX_MAX + 1);
    localparam int NEVER = 1000000;

    logic            clk = 1'b0;
    logic            rst, start, abort, sim_done;
    logic [TW-1:0]   timeout_cycles;
    logic [ERRW-1:0] err_count;
    logic            emu_rst, busy, done;
    logic [TXW-1:0]  tx_setting;
    logic [RXW-1:0]  rx_setting;

    setting_sweep_ctrl_if #(.TX_W(TXW), .RX_W(RXW), .ERR_W(ERRW)) res_if ();

    setting_sweep_ctrl #(
        .TX_SETTING_WIDTH(TXW), .RX_SETTING_WIDTH(RXW), .TX_MAX(TX_MAX), .RX_MAX(RX_MAX),
        .ERR_WIDTH(ERRW), .RST_CYCLES(RSTC), .BLANK_CYCLES(BLANK), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .timeout_cycles_i(timeout_cycles), .sim_done_i(sim_done), .err_count_i(err_count),
        .emu_rst_o(emu_rst), .tx_setting_o(tx_setting), .rx_setting_o(rx_setting),
        .busy_o(busy), .done_o(done), .res(res_if)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Emulator: sim_done rises emu_delay cycles after emu_rst falls; optional stale pulse in blanking.
    int emu_delay = 100;
    bit emu_stale = 0;
    int ecnt = 0;
    initial begin sim_done = 0; err_count = '0; end
    always @(posedge clk) begin
        #1;
        if (emu_rst) ecnt = 0;
        else if (ecnt < NEVER) ecnt++;
        sim_done  = (emu_stale && ecnt >= 1 && ecnt <= BLANK) || (ecnt > emu_delay);
        err_count = ERRW'(tx_setting) * 16 + ERRW'(rx_setting);
    end

    bit bp_hold = 0;
    int ready_pct = 100;
    initial res_if.res_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        res_if.res_ready = bp_hold ? 1'b0 : ($urandom_range(99) < ready_pct);
    end

    // Scoreboard and per-cycle compare.
    bit armed = 0;
    int exp_idx = 0;
    int hi_cnt = 0, low_cnt = 0, last_low = -1;
    logic last_to = 1'b0;
    logic [ERRW-1:0] err_log[$];
    logic pv_hold = 0, pv_busy = 0, pv_emu = 1;
    logic [TXW-1:0] pv_tx = '0, pv_rtx = '0;
    logic [RXW-1:0] pv_rx = '0, pv_rrx = '0;
    logic [ERRW-1:0] pv_rerr = '0;
    logic pv_rto = 0;

    always @(negedge clk) begin
        int etx, erx, t, kend;
        t = int'(timeout_cycles);
        kend = emu_delay;
        if (t != 0 && t - 1 < emu_delay) kend = t - 1;
        if (armed && !rst) begin
            if (res_if.res_valid && res_if.res_ready) begin
                etx = exp_idx / (RX_MAX + 1);
                erx = exp_idx % (RX_MAX + 1);
                chk("res_in_range", exp_idx < NPTS, 1);
                chk("res_tx", res_if.res_tx, etx);
                chk("res_rx", res_if.res_rx, erx);
                chk("res_err", res_if.res_err, etx * 16 + erx);
                chk("res_timeout", res_if.res_timeout, (t != 0 && t - 1 < emu_delay));
                last_to = res_if.res_timeout;
                err_log.push_back(res_if.res_err);
                exp_idx++;
            end
            if (pv_hold) begin
                chk("hold_valid", res_if.res_valid, 1);
                chk("hold_res_tx", res_if.res_tx, pv_rtx);
                chk("hold_res_rx", res_if.res_rx, pv_rrx);
                chk("hold_res_err", res_if.res_err, pv_rerr);
                chk("hold_res_to", res_if.res_timeout, pv_rto);
                chk("hold_settings", {tx_setting, rx_setting}, {pv_tx, pv_rx});
                chk("hold_emu_rst", emu_rst, 1);
            end
            if (busy && (!pv_busy || tx_setting != pv_tx || rx_setting != pv_rx)) hi_cnt = 1;
            else if (emu_rst) hi_cnt++;
            if (busy && pv_emu && !emu_rst) chk("apply_len", hi_cnt, RSTC);
            if (busy && !emu_rst) low_cnt++;
            else begin
                if (busy && !pv_emu) begin
                    chk("run_len", low_cnt, kend + 2);
                    last_low = low_cnt;
                end
                low_cnt = 0;
            end
        end
        pv_hold = armed && res_if.res_valid && !res_if.res_ready;
        pv_busy = busy;
        pv_emu  = emu_rst;
        pv_tx   = tx_setting;
        pv_rx   = rx_setting;
        pv_rtx  = res_if.res_tx;
        pv_rrx  = res_if.res_rx;
        pv_rerr = res_if.res_err;
        pv_rto  = res_if.res_timeout;
    end

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic start_pulse();
        nstep();
        start = 1'b1;
        exp_idx = 0;
        err_log.delete();
        armed = 1;
        nstep();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 6000) begin nstep(); n++; end
        chk({name, "_done"}, done, 1);
        chk({name, "_points"}, exp_idx, NPTS);
        chk({name, "_idle_busy"}, busy, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_emu_rst"}, emu_rst, 1);
        chk({name, "_settings"}, {tx_setting, rx_setting}, 0);
        chk({name, "_res_valid"}, res_if.res_valid, 0);
        chk({name, "_res_fields"}, {res_if.res_tx, res_if.res_rx, res_if.res_err, res_if.res_timeout}, 0);
        chk({name, "_busy_done"}, {busy, done}, 0);
    endtask

    int exp_errs[4] = '{0, 1, 16, 17};

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0; timeout_cycles = '0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic 2x2 sweep with 50-cycle backpressure on the first result.
        emu_delay = 100; emu_stale = 0; timeout_cycles = 0; ready_pct = 100; bp_hold = 1;
        start_pulse();
        chk("first_apply", {busy, emu_rst, tx_setting, rx_setting}, {1'b1, 1'b1, 8'h00});
        n = 0;
        while (!res_if.res_valid && n < 2000) begin nstep(); n++; end
        chk("first_result_seen", res_if.res_valid, 1);
        repeat (50) nstep();
        bp_hold = 0;
        nstep();
        chk("bp_still_valid", res_if.res_valid, 1);
        nstep();
        chk("bp_next_cycle", {res_if.res_valid, busy, tx_setting, rx_setting}, {1'b0, 1'b1, 8'h00});
        nstep();
        chk("bp_resume", {emu_rst, tx_setting, rx_setting}, {1'b1, 8'h01});
        wait_done("basic");
        chk("basic_last_settings", {tx_setting, rx_setting}, {4'd1, 4'd1});
        chk("basic_run_len", last_low, 102);
        chk("basic_log_size", err_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (err_log.size() > i) chk("basic_err_literal", err_log[i], exp_errs[i]);

        // Restart from DONE, stale sim_done in blanking, start pulse while busy.
        emu_delay = BLANK + 10; emu_stale = 1; ready_pct = 60;
        start_pulse();
        chk("restart_from_done", {done, busy, emu_rst, tx_setting, rx_setting}, {1'b0, 1'b1, 1'b1, 8'h00});
        repeat (30) nstep();
        start = 1'b1;
        nstep();
        start = 1'b0;
        chk("start_while_busy", {busy, tx_setting, rx_setting}, {1'b1, 8'h00});
        wait_done("stale");
        chk("stale_run_len", last_low, 16);

        // Timeout with sim_done never rising, then timeout tying with sim_done.
        emu_delay = NEVER; emu_stale = 0; timeout_cycles = 200; ready_pct = 100;
        start_pulse();
        wait_done("timeout");
        chk("timeout_flag", last_to, 1);
        chk("timeout_run_len", last_low, 201);
        emu_delay = 199;
        start_pulse();
        wait_done("tie");
        chk("tie_flag", last_to, 0);
        chk("tie_run_len", last_low, 201);

        // Abort during RUN of (0,1).
        emu_delay = 100; timeout_cycles = 0;
        start_pulse();
        n = 0;
        while (!(busy && !emu_rst && tx_setting == 0 && rx_setting == 1) && n < 2000) begin nstep(); n++; end
        chk("abort_reach_run01", {tx_setting, rx_setting, emu_rst}, {8'h01, 1'b0});
        repeat (20) nstep();
        armed = 0;
        abort = 1'b1;
        nstep();
        abort = 1'b0;
        chk("abort_idle", {busy, done, emu_rst, res_if.res_valid}, {1'b0, 1'b0, 1'b1, 1'b0});
        chk("abort_settings_hold", {tx_setting, rx_setting}, 8'h01);

        // Restart, then async reset while a result is pending.
        bp_hold = 1;
        start_pulse();
        chk("abort_restart", {busy, tx_setting, rx_setting}, {1'b1, 8'h00});
        n = 0;
        while (!res_if.res_valid && n < 2000) begin nstep(); n++; end
        chk("report_reached", res_if.res_valid, 1);
        armed = 0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        nstep();
        rst = 1'b0;
        bp_hold = 0;
        start_pulse();
        chk("rst_restart", {busy, tx_setting, rx_setting}, {1'b1, 8'h00});
        wait_done("post_rst");

        // Randomized sweeps.
        for (int s = 0; s < 6; s++) begin
            emu_delay = $urandom_range(150, BLANK);
            emu_stale = $urandom_range(1, 0);
            case ($urandom_range(2, 0))
                0: timeout_cycles = 0;
                1: timeout_cycles = $urandom_range(emu_delay + 20, 1);
                default: timeout_cycles = emu_delay + 1;
            endcase
            ready_pct = $urandom_range(100, 20);
            start_pulse();
            wait_done("random");
        end

        armed = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
